// File: rtl/fetch_pc_gen.sv
// Fetch-stage PC generator.
// Drives the fetch PC into the bimodal predictor and steers the next PC from
// the same-cycle prediction. Every accepted fetch is remembered in a small
// in-flight queue until execute resolves it. A resolution that disagrees with
// the stored prediction redirects fetch on the following cycle.
module fetch_pc_gen #(
    parameter logic [63:0] RESET_PC = 64'h0000_0000_0000_0100,
    parameter int          QDEPTH   = 4
) (
    input  logic        clk_i,
    input  logic        rstn_i,
    input  logic        fetch_ready_i,
    input  logic        bimodal_predict_taken_i,
    input  logic [63:0] bimodal_predict_addr_i,
    input  logic        exec_valid_i,
    input  logic        exec_is_branch_i,
    input  logic        exec_taken_i,
    input  logic [63:0] exec_target_i,
    input  logic        flush_i,
    input  logic [63:0] flush_addr_i,
    output logic [63:0] pc_fetch_o,
    output logic        fetch_valid_o,
    output logic [63:0] pc_execution_o,
    output logic        is_branch_EX_o,
    output logic        branch_taken_result_exec_o,
    output logic [63:0] branch_addr_result_exec_o,
    output logic        mispredict_o,
    output logic        underflow_err_o
);

    localparam int PW = $clog2(QDEPTH);
    localparam int CW = PW + 1;

    // In-flight prediction storage: fetch PC, predicted direction, predicted target
    logic [63:0] q_pc     [QDEPTH];
    logic        q_taken  [QDEPTH];
    logic [63:0] q_target [QDEPTH];

    logic [PW-1:0] rd_ptr;
    logic [PW-1:0] wr_ptr;
    logic [CW-1:0] count;

    logic [63:0] pc_q;
    logic        mispredict_q;
    logic        underflow_q;

    logic [63:0] head_pc;
    logic        head_taken;
    logic [63:0] head_target;
    logic        not_empty;
    logic        resolve;
    logic        wrong_pred;
    logic        mispredict_now;
    logic [63:0] correct_pc;
    logic        fetch_valid;
    logic        accept;
    logic [63:0] predicted_pc;

    // Resolution check against the oldest in-flight prediction, plus fetch acceptance
    always_comb begin
        head_pc     = q_pc[rd_ptr];
        head_taken  = q_taken[rd_ptr];
        head_target = q_target[rd_ptr];
        not_empty   = (count != '0);
        resolve     = exec_valid_i & not_empty;

        // A non-branch always falls through; a taken branch goes to its resolved target
        if (exec_is_branch_i && exec_taken_i) begin
            correct_pc = exec_target_i;
        end else begin
            correct_pc = head_pc + 64'd4;
        end

        // Non-branches are wrong only if predicted taken; branches also compare targets when both taken
        if (exec_is_branch_i) begin
            wrong_pred = (head_taken != exec_taken_i) |
                         (head_taken & exec_taken_i & (head_target != exec_target_i));
        end else begin
            wrong_pred = head_taken;
        end

        mispredict_now = resolve & wrong_pred;
        fetch_valid    = (count < CW'(QDEPTH)) & ~flush_i & ~mispredict_now;
        accept         = fetch_valid & fetch_ready_i;
        predicted_pc   = bimodal_predict_taken_i ? bimodal_predict_addr_i : (pc_q + 64'd4);
    end

    // PC, queue bookkeeping and status flags; flush beats mispredict beats normal flow
    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            pc_q         <= RESET_PC;
            rd_ptr       <= '0;
            wr_ptr       <= '0;
            count        <= '0;
            mispredict_q <= 1'b0;
            underflow_q  <= 1'b0;
        end else begin
            if (exec_valid_i && !not_empty) begin
                underflow_q <= 1'b1;
            end

            if (flush_i) begin
                pc_q         <= flush_addr_i;
                rd_ptr       <= '0;
                wr_ptr       <= '0;
                count        <= '0;
                mispredict_q <= 1'b0;
            end else if (mispredict_now) begin
                pc_q         <= correct_pc;
                rd_ptr       <= '0;
                wr_ptr       <= '0;
                count        <= '0;
                mispredict_q <= 1'b1;
            end else begin
                mispredict_q <= 1'b0;
                if (accept) begin
                    pc_q   <= predicted_pc;
                    wr_ptr <= wr_ptr + PW'(1);
                end
                if (resolve) begin
                    rd_ptr <= rd_ptr + PW'(1);
                end
                if (accept && !resolve) begin
                    count <= count + CW'(1);
                end else if (!accept && resolve) begin
                    count <= count - CW'(1);
                end
            end
        end
    end

    // Queue payload needs no reset: entries are only read while count says they are live
    always_ff @(posedge clk_i) begin
        if (accept) begin
            q_pc[wr_ptr]     <= pc_q;
            q_taken[wr_ptr]  <= bimodal_predict_taken_i;
            q_target[wr_ptr] <= bimodal_predict_addr_i;
        end
    end

    assign pc_fetch_o                 = pc_q;
    assign fetch_valid_o              = fetch_valid;
    assign pc_execution_o             = not_empty ? head_pc : 64'd0;
    assign is_branch_EX_o             = exec_valid_i & exec_is_branch_i;
    assign branch_taken_result_exec_o = exec_taken_i;
    assign branch_addr_result_exec_o  = exec_target_i;
    assign mispredict_o               = mispredict_q;
    assign underflow_err_o            = underflow_q;

endmodule

// File: tb/tb_fetch_pc_gen.sv
// Testbench for fetch_pc_gen: directed scenarios followed by random traffic,
// all compared against a queue-based reference model of the fetch stage.
module tb_fetch_pc_gen;

    localparam logic [63:0] RESET_PC = 64'h0000_0000_0000_0100;
    localparam int          QDEPTH   = 4;

    logic        clk_i = 1'b0;
    logic        rstn_i;
    logic        fetch_ready_i;
    logic        bimodal_predict_taken_i;
    logic [63:0] bimodal_predict_addr_i;
    logic        exec_valid_i;
    logic        exec_is_branch_i;
    logic        exec_taken_i;
    logic [63:0] exec_target_i;
    logic        flush_i;
    logic [63:0] flush_addr_i;
    logic [63:0] pc_fetch_o;
    logic        fetch_valid_o;
    logic [63:0] pc_execution_o;
    logic        is_branch_EX_o;
    logic        branch_taken_result_exec_o;
    logic [63:0] branch_addr_result_exec_o;
    logic        mispredict_o;
    logic        underflow_err_o;

    int testCount = 0;
    int failCount = 0;

    typedef struct {
        logic [63:0] pc;
        logic        taken;
        logic [63:0] target;
    } entry_t;

    // Reference model state
    entry_t      mQueue[$];
    logic [63:0] mPc;
    logic        mMis;
    logic        mErr;

    fetch_pc_gen #(.RESET_PC(RESET_PC), .QDEPTH(QDEPTH)) dut (
        .clk_i                      (clk_i),
        .rstn_i                     (rstn_i),
        .fetch_ready_i              (fetch_ready_i),
        .bimodal_predict_taken_i    (bimodal_predict_taken_i),
        .bimodal_predict_addr_i     (bimodal_predict_addr_i),
        .exec_valid_i               (exec_valid_i),
        .exec_is_branch_i           (exec_is_branch_i),
        .exec_taken_i               (exec_taken_i),
        .exec_target_i              (exec_target_i),
        .flush_i                    (flush_i),
        .flush_addr_i               (flush_addr_i),
        .pc_fetch_o                 (pc_fetch_o),
        .fetch_valid_o              (fetch_valid_o),
        .pc_execution_o             (pc_execution_o),
        .is_branch_EX_o             (is_branch_EX_o),
        .branch_taken_result_exec_o (branch_taken_result_exec_o),
        .branch_addr_result_exec_o  (branch_addr_result_exec_o),
        .mispredict_o               (mispredict_o),
        .underflow_err_o            (underflow_err_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
        testCount++;
        if (observed !== expected) begin
            failCount++;
            $display("[TB] FAIL %s: got %h, expected %h", tag, observed, expected);
        end
    endtask

    task automatic modelReset();
        mQueue.delete();
        mPc  = RESET_PC;
        mMis = 1'b0;
        mErr = 1'b0;
    endtask

    // Drive one cycle of inputs (called at a negedge), check outputs, advance the model across posedge
    task automatic applyStimulus(input logic ready, input logic pTaken, input logic [63:0] pAddr,
                                 input logic ev, input logic eb, input logic et, input logic [63:0] eTgt,
                                 input logic fl, input logic [63:0] fAddr);
        bit          misNow;
        bit          fv;
        logic [63:0] correct;
        entry_t      head;
        entry_t      e;
        fetch_ready_i           = ready;
        bimodal_predict_taken_i = pTaken;
        bimodal_predict_addr_i  = pAddr;
        exec_valid_i            = ev;
        exec_is_branch_i        = eb;
        exec_taken_i            = et;
        exec_target_i           = eTgt;
        flush_i                 = fl;
        flush_addr_i            = fAddr;
        #1;
        misNow  = 1'b0;
        correct = 64'd0;
        if (mQueue.size() > 0) begin
            head = mQueue[0];
            if (eb) begin
                misNow  = ev && ((head.taken != et) || (head.taken && et && head.target != eTgt));
                correct = et ? eTgt : head.pc + 64'd4;
            end else begin
                misNow  = ev && head.taken;
                correct = head.pc + 64'd4;
            end
        end
        fv = (mQueue.size() < QDEPTH) && !fl && !misNow;

        checkOutput("pc_fetch", pc_fetch_o, mPc);
        checkOutput("fetch_valid", 64'(fetch_valid_o), 64'(fv));
        checkOutput("pc_execution", pc_execution_o, (mQueue.size() > 0) ? mQueue[0].pc : 64'd0);
        checkOutput("is_branch_EX", 64'(is_branch_EX_o), 64'(ev & eb));
        checkOutput("taken_pass", 64'(branch_taken_result_exec_o), 64'(et));
        checkOutput("addr_pass", branch_addr_result_exec_o, eTgt);
        checkOutput("mispredict", 64'(mispredict_o), 64'(mMis));
        checkOutput("underflow", 64'(underflow_err_o), 64'(mErr));

        if (ev && mQueue.size() == 0) mErr = 1'b1;
        if (fl) begin
            mPc = fAddr;
            mQueue.delete();
            mMis = 1'b0;
        end else if (misNow) begin
            mPc = correct;
            mQueue.delete();
            mMis = 1'b1;
        end else begin
            mMis = 1'b0;
            if (ev && mQueue.size() > 0) void'(mQueue.pop_front());
            if (fv && ready) begin
                e.pc     = mPc;
                e.taken  = pTaken;
                e.target = pAddr;
                mQueue.push_back(e);
                mPc = pTaken ? pAddr : mPc + 64'd4;
            end
        end
        @(posedge clk_i);
        @(negedge clk_i);
    endtask

    // Asynchronous reset in the middle of a cycle: outputs must return to reset values without a clock
    task automatic midReset();
        rstn_i = 1'b0;
        fetch_ready_i = 1'b0; bimodal_predict_taken_i = 1'b0; bimodal_predict_addr_i = '0;
        exec_valid_i = 1'b0; exec_is_branch_i = 1'b0; exec_taken_i = 1'b0; exec_target_i = '0;
        flush_i = 1'b0; flush_addr_i = '0;
        #1;
        modelReset();
        checkOutput("rst_pc", pc_fetch_o, RESET_PC);
        checkOutput("rst_valid", 64'(fetch_valid_o), 64'd1);
        checkOutput("rst_pcexec", pc_execution_o, 64'd0);
        checkOutput("rst_mispredict", 64'(mispredict_o), 64'd0);
        checkOutput("rst_underflow", 64'(underflow_err_o), 64'd0);
        @(posedge clk_i);
        @(negedge clk_i);
        rstn_i = 1'b1;
    endtask

    initial begin
        logic        ready, pT, ev, eb, et, fl;
        logic [63:0] pA, eT, fA;

        rstn_i = 1'b0;
        @(negedge clk_i);
        midReset();

        // Sequential fetch from RESET_PC until the queue fills
        for (int i = 0; i < 5; i++) applyStimulus(1, 0, 0, 0, 0, 0, 0, 0, 0);
        checkOutput("full_hold_pc", pc_fetch_o, 64'h110);
        // Non-branch resolve frees one slot
        applyStimulus(1, 0, 0, 1, 0, 0, 0, 0, 0);
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0);
        // Correctly predicted taken branch
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 1, 64'h200);
        applyStimulus(1, 1, 64'h400, 0, 0, 0, 0, 0, 0);
        applyStimulus(0, 0, 0, 1, 1, 1, 64'h400, 0, 0);
        checkOutput("taken_ok_pc", pc_fetch_o, 64'h400);
        // Predicted taken, resolved not taken
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 1, 64'h200);
        applyStimulus(1, 1, 64'h400, 0, 0, 0, 0, 0, 0);
        applyStimulus(1, 0, 0, 1, 1, 0, 64'h0, 0, 0);
        checkOutput("mis_redirect_pc", pc_fetch_o, 64'h204);
        checkOutput("mis_pulse", 64'(mispredict_o), 64'd1);
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0);
        // Mispredict coinciding with flush
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 1, 64'h200);
        applyStimulus(1, 1, 64'h400, 0, 0, 0, 0, 0, 0);
        applyStimulus(1, 0, 0, 1, 1, 0, 64'h0, 1, 64'h8000);
        checkOutput("flush_pc", pc_fetch_o, 64'h8000);
        // Resolve with empty queue, then 64-bit wrap of sequential PC
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 1, 64'hFFFF_FFFF_FFFF_FFFC);
        applyStimulus(1, 0, 0, 1, 1, 1, 64'h40, 0, 0);
        checkOutput("wrap_pc", pc_fetch_o, 64'h0);
        checkOutput("underflow_set", 64'(underflow_err_o), 64'd1);
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0);
        midReset();

        // Random traffic
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 199) == 0) begin
                midReset();
            end else begin
                ready = ($urandom_range(0, 3) != 0);
                pT    = ($urandom_range(0, 9) < 3);
                pA    = {$urandom, $urandom} & ~64'h3;
                ev    = ($urandom_range(0, 9) < 4);
                eb    = $urandom_range(0, 1);
                et    = $urandom_range(0, 1);
                eT    = {$urandom, $urandom} & ~64'h3;
                if (mQueue.size() > 0 && $urandom_range(0, 9) < 6) begin
                    eb = 1'b1;
                    et = mQueue[0].taken;
                    eT = mQueue[0].target;
                end
                fl = ($urandom_range(0, 19) == 0);
                fA = ($urandom_range(0, 3) == 0) ? 64'hFFFF_FFFF_FFFF_FFF8 : ({$urandom, $urandom} & ~64'h3);
                applyStimulus(ready, pT, pA, ev, eb, et, eT, fl, fA);
            end
        end

        $display("[TB] %0d tests run, %0d failed", testCount, failCount);
        $finish;
    end

endmodule
